// File: rtl/hazard_ctrl_if.sv
// D-stage decode timing in, stall / bypass selects / HI-LO status out.
interface hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
);
    logic [REG_AW-1:0] d_rs;
    logic [REG_AW-1:0] d_rt;
    logic [1:0]        d_tuse_rs;
    logic [1:0]        d_tuse_rt;
    logic [REG_AW-1:0] d_wa;
    logic [1:0]        d_tnew;
    logic              d_md;
    logic [1:0]        d_md_start;

    logic              stall;
    logic [1:0]        f_d_rs;
    logic [1:0]        f_d_rt;
    logic [1:0]        f_e_rs;
    logic [1:0]        f_e_rt;
    logic [1:0]        f_m_rt;
    logic              md_busy;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_tnew, d_md, d_md_start,
        input  stall, f_d_rs, f_d_rt, f_e_rs, f_e_rt, f_m_rt, md_busy, stall_cnt
    );

    modport slave (
        input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_tnew, d_md, d_md_start,
        output stall, f_d_rs, f_d_rt, f_e_rs, f_e_rt, f_m_rt, md_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Tuse/Tnew hazard controller: shadow E/M/W timing, stall, bypass selects,
// HI/LO busy window and a saturating stall counter.
module hazard_ctrl #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 32
) (
    input logic           clk,
    input logic           reset,
    hazard_ctrl_if.slave  hz
);
    localparam int unsigned MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned MD_W   = $clog2(MD_MAX + 1);

    typedef struct packed {
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [1:0]        tuse_rs;
        logic [1:0]        tuse_rt;
        logic [REG_AW-1:0] wa;
        logic [1:0]        tnew;
    } stage_t;

    localparam stage_t BUBBLE = '{rs: '0, rt: '0, tuse_rs: 2'd3, tuse_rt: 2'd3,
                                  wa: '0, tnew: 2'd0};

    stage_t            e_q, m_q, w_q, d_s;
    logic [1:0]        e_start_q;
    logic [1:0]        d_start_c;
    logic [MD_W-1:0]   md_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              stall_c;
    logic              unused_w;

    // One pipe step of aging: tuse 3 means "not read" and never decays.
    function automatic stage_t age(input stage_t s);
        stage_t r;
        r = s;
        if (s.tuse_rs != 2'd3 && s.tuse_rs != 2'd0) r.tuse_rs = s.tuse_rs - 2'd1;
        if (s.tuse_rt != 2'd3 && s.tuse_rt != 2'd0) r.tuse_rt = s.tuse_rt - 2'd1;
        if (s.tnew != 2'd0)                         r.tnew    = s.tnew - 2'd1;
        return r;
    endfunction

    // Select of the nearest producer among the enabled older stages, if its value is ready.
    function automatic logic [1:0] pick(input logic [REG_AW-1:0] r,
                                        input logic use_e, input logic use_m,
                                        input stage_t e, input stage_t m, input stage_t w);
        logic [1:0] sel;
        sel = 2'd0;
        if (r != '0) begin
            if (use_e && e.wa == r) begin
                if (e.tnew == 2'd0) sel = 2'd1;
            end else if (use_m && m.wa == r) begin
                if (m.tnew == 2'd0) sel = 2'd2;
            end else if (w.wa == r) begin
                if (w.tnew == 2'd0) sel = 2'd3;
            end
        end
        return sel;
    endfunction

    // A read operand must wait if its nearest E/M producer is not ready in time.
    function automatic logic need_stall(input logic [REG_AW-1:0] r, input logic [1:0] tuse,
                                        input stage_t e, input stage_t m);
        logic s;
        s = 1'b0;
        if (tuse != 2'd3 && r != '0) begin
            if (e.wa == r)      s = (e.tnew > tuse);
            else if (m.wa == r) s = (m.tnew > tuse);
        end
        return s;
    endfunction

    always_comb begin
        d_s         = BUBBLE;
        d_s.rs      = hz.d_rs;
        d_s.rt      = hz.d_rt;
        d_s.tuse_rs = hz.d_tuse_rs;
        d_s.tuse_rt = hz.d_tuse_rt;
        d_s.wa      = hz.d_wa;
        d_s.tnew    = hz.d_tnew;
        d_start_c   = (hz.d_md_start == 2'd3) ? 2'd0 : hz.d_md_start;
    end

    always_comb begin
        stall_c = need_stall(hz.d_rs, hz.d_tuse_rs, e_q, m_q)
                | need_stall(hz.d_rt, hz.d_tuse_rt, e_q, m_q)
                | (hz.d_md && (md_cnt_q != '0 || e_start_q != 2'd0));
    end

    assign hz.stall     = stall_c;
    assign hz.f_d_rs    = pick(hz.d_rs, 1'b1, 1'b1, e_q, m_q, w_q);
    assign hz.f_d_rt    = pick(hz.d_rt, 1'b1, 1'b1, e_q, m_q, w_q);
    assign hz.f_e_rs    = pick(e_q.rs,  1'b0, 1'b1, e_q, m_q, w_q);
    assign hz.f_e_rt    = pick(e_q.rt,  1'b0, 1'b1, e_q, m_q, w_q);
    assign hz.f_m_rt    = pick(m_q.rt,  1'b0, 1'b0, e_q, m_q, w_q);
    assign hz.md_busy   = (md_cnt_q != '0);
    assign hz.stall_cnt = stall_cnt_q;

    // W operand timing is kept for completeness but nothing downstream reads it.
    assign unused_w = ^{w_q.rs, w_q.rt, w_q.tuse_rs, w_q.tuse_rt};

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q         <= BUBBLE;
            m_q         <= BUBBLE;
            w_q         <= BUBBLE;
            e_start_q   <= 2'd0;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            e_q       <= stall_c ? BUBBLE : d_s;
            e_start_q <= stall_c ? 2'd0 : d_start_c;
            m_q       <= age(e_q);
            w_q       <= age(m_q);

            // A start entering E reloads the busy window even if one is in flight.
            if (!stall_c && d_start_c == 2'd1)      md_cnt_q <= MD_W'(MULT_CYCLES);
            else if (!stall_c && d_start_c == 2'd2) md_cnt_q <= MD_W'(DIV_CYCLES);
            else if (md_cnt_q != '0)                md_cnt_q <= md_cnt_q - MD_W'(1);

            if (stall_c && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with immediate-assertion checks.
module tb_hazard_ctrl;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) hz ();

    hazard_ctrl #(
        .REG_AW(5), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_d(input int rs, input int rt, input int tuse_rs, input int tuse_rt,
                         input int wa, input int tnew, input int md, input int start);
        hz.d_rs       = 5'(rs);
        hz.d_rt       = 5'(rt);
        hz.d_tuse_rs  = 2'(tuse_rs);
        hz.d_tuse_rt  = 2'(tuse_rt);
        hz.d_wa       = 5'(wa);
        hz.d_tnew     = 2'(tnew);
        hz.d_md       = md[0];
        hz.d_md_start = 2'(start);
    endtask

    task automatic nop();
        set_d(0, 0, 3, 3, 0, 0, 0, 0);
    endtask

    // Advance one clock; inputs change and outputs are sampled just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic md_window(input string tag, input int start, input int exp_cycles,
                             input int exp_cnt);
        int n_stall;
        int n_busy;
        n_stall = 0;
        n_busy  = 0;
        set_d(10, 11, 1, 1, 0, 0, 1, start);
        #1 check({tag, "_issue_stall"}, 32'(hz.stall), 0);
        tick();
        set_d(0, 0, 3, 3, 12, 1, 1, 0);
        #1;
        for (int i = 0; i < 30; i++) begin
            if (!hz.stall) break;
            n_stall++;
            if (hz.md_busy) n_busy++;
            tick();
        end
        check({tag, "_stall_cycles"}, 32'(n_stall), 32'(exp_cycles));
        check({tag, "_busy_cycles"}, 32'(n_busy), 32'(exp_cycles));
        check({tag, "_busy_end"}, 32'(hz.md_busy), 0);
        check({tag, "_stall_cnt"}, hz.stall_cnt, 32'(exp_cnt));
        tick();
        drain();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        nop();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_stall", 32'(hz.stall), 0);
        check("rst_fwd", 32'({hz.f_d_rs, hz.f_d_rt, hz.f_e_rs, hz.f_e_rt, hz.f_m_rt}), 0);
        check("rst_md_busy", 32'(hz.md_busy), 0);
        check("rst_stall_cnt", hz.stall_cnt, 0);

        // addu r3 (tnew 1) then beq on r3 (tuse 0)
        set_d(1, 2, 1, 1, 3, 1, 0, 0);
        #1 check("addu_no_stall", 32'(hz.stall), 0);
        tick();
        set_d(3, 0, 0, 3, 0, 0, 0, 0);
        #1 check("beq_stall", 32'(hz.stall), 1);
        tick();
        check("beq_released", 32'(hz.stall), 0);
        check("beq_f_d_rs", 32'(hz.f_d_rs), 2);
        check("beq_stall_cnt", hz.stall_cnt, 1);
        tick();
        drain();

        // lw r5 (tnew 2) then addu using r5 (tuse 1)
        set_d(4, 0, 1, 3, 5, 2, 0, 0);
        tick();
        set_d(5, 6, 1, 1, 7, 1, 0, 0);
        #1 check("lw_use_stall", 32'(hz.stall), 1);
        tick();
        check("lw_use_released", 32'(hz.stall), 0);
        check("lw_use_f_d_rs", 32'(hz.f_d_rs), 0);
        tick();
        nop();
        #1 check("lw_use_f_e_rs", 32'(hz.f_e_rs), 3);
        check("lw_use_stall_cnt", hz.stall_cnt, 2);
        drain();

        // jal r31 (tnew 0) then jr r31
        set_d(0, 0, 3, 3, 31, 0, 0, 0);
        tick();
        set_d(31, 0, 0, 3, 0, 0, 0, 0);
        #1 check("jr_stall", 32'(hz.stall), 0);
        check("jr_f_d_rs", 32'(hz.f_d_rs), 1);
        tick();
        drain();

        // writes to r0 never create hazards or bypasses
        set_d(0, 0, 3, 3, 0, 2, 0, 0);
        tick();
        set_d(0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("zero_stall", 32'(hz.stall), 0);
        check("zero_fwd", 32'({hz.f_d_rs, hz.f_d_rt}), 0);
        tick();
        drain();

        // r8 produced in M and again in E: the younger (E) one wins
        set_d(0, 0, 3, 3, 8, 1, 0, 0);
        tick();
        set_d(0, 0, 3, 3, 8, 0, 0, 0);
        tick();
        set_d(8, 0, 0, 3, 0, 0, 0, 0);
        #1 check("two_prod_stall", 32'(hz.stall), 0);
        check("two_prod_f_d_rs", 32'(hz.f_d_rs), 1);
        tick();
        nop();
        #1 check("two_prod_f_e_rs", 32'(hz.f_e_rs), 2);
        drain();

        // store data on r9 follows its producer down the pipe
        set_d(0, 0, 3, 3, 9, 1, 0, 0);
        tick();
        set_d(0, 9, 3, 2, 0, 0, 0, 0);
        #1 check("st_stall", 32'(hz.stall), 0);
        check("st_f_d_rt", 32'(hz.f_d_rt), 0);
        tick();
        nop();
        #1 check("st_f_e_rt", 32'(hz.f_e_rt), 2);
        tick();
        check("st_f_m_rt", 32'(hz.f_m_rt), 3);
        drain();

        md_window("div", 2, 10, 12);
        md_window("mult", 1, 5, 17);

        // reset three cycles into a div aborts the busy window
        set_d(10, 11, 1, 1, 0, 0, 1, 2);
        tick();
        nop();
        #1 check("abort_busy_pre", 32'(hz.md_busy), 1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1 check("abort_md_busy", 32'(hz.md_busy), 0);
        check("abort_stall_cnt", hz.stall_cnt, 0);
        check("abort_fwd", 32'({hz.f_d_rs, hz.f_d_rt, hz.f_e_rs, hz.f_e_rt, hz.f_m_rt}), 0);
        set_d(0, 0, 3, 3, 12, 1, 1, 0);
        #1 check("abort_mflo_stall", 32'(hz.stall), 0);
        tick();
        nop();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
